gate_and_dmux_unit: RTL and testbench

- Registered bit-logic unit. Computes a 16-bit bitwise AND, a 1-bit AND and a 1-to-2 demultiplexer from one set of input operands.
- All results are captured in output registers, one clock after a qualified input.
- Sits in the ALU/logic datapath as the synchronous wrapper for the basic and16, and2 and dmux gate functions.

---
 rtl/logic_pkg.sv | 6 +
 rtl/and_bit_cell.sv | 8 +
 rtl/gate_and_dmux_unit.sv | 89 ++++++++
 tb/tb_gate_and_dmux_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared word-width constants and types for the gate/demux datapath.
package logic_pkg;
    localparam int WORD_W = 16;
    typedef logic [WORD_W-1:0] word_t;
    localparam word_t ZERO_WORD = 16'h0000;
endpackage

// File: rtl/and_bit_cell.sv
// Single 2-input AND gate cell; the primitive for the wide AND, narrow AND and demux legs.
module and_bit_cell (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a & i_b;
endmodule

// File: rtl/gate_and_dmux_unit.sv
// Registered and16 / and2 / dmux wrapper with one-cycle latency.
// Optional AND16_ZERO_FLAG_EN adds a registered y16_zero flag.
module gate_and_dmux_unit
    import logic_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a16,
    input  logic [WIDTH-1:0] b16,
    input  logic             a,
    input  logic             b,
    input  logic             in,
    input  logic             sel,
    output logic             valid_out,
    output logic [WIDTH-1:0] y16,
    output logic             y,
    output logic             dmux_a,
`ifdef AND16_ZERO_FLAG_EN
    output logic             y16_zero,
`endif
    output logic             dmux_b
);
    logic [WIDTH-1:0] w_y16;
    logic             w_y;
    logic             w_dmux_a;
    logic             w_dmux_b;
    logic             w_sel_n;

    logic             r_valid;
    logic [WIDTH-1:0] r_y16;
    logic             r_y;
    logic             r_dmux_a;
    logic             r_dmux_b;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_and16
            and_bit_cell u_cell (.i_a(a16[gi]), .i_b(b16[gi]), .o_y(w_y16[gi]));
        end
    endgenerate

    and_bit_cell u_and2 (.i_a(a), .i_b(b), .o_y(w_y));

    // Demux legs: each output is the data bit gated by its select polarity.
    assign w_sel_n = ~sel;
    and_bit_cell u_dmux_a (.i_a(in), .i_b(w_sel_n), .o_y(w_dmux_a));
    and_bit_cell u_dmux_b (.i_a(in), .i_b(sel),     .o_y(w_dmux_b));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_y16    <= '0;
            r_y      <= 1'b0;
            r_dmux_a <= 1'b0;
            r_dmux_b <= 1'b0;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_y16    <= w_y16;
                r_y      <= w_y;
                r_dmux_a <= w_dmux_a;
                r_dmux_b <= w_dmux_b;
            end
        end
    end

`ifdef AND16_ZERO_FLAG_EN
    logic r_y16_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y16_zero <= 1'b0;
        end else if (valid_in) begin
            r_y16_zero <= (w_y16 == ZERO_WORD[WIDTH-1:0]);
        end
    end

    assign y16_zero = r_y16_zero;
`endif

    assign valid_out = r_valid;
    assign y16       = r_y16;
    assign y         = r_y;
    assign dmux_a    = r_dmux_a;
    assign dmux_b    = r_dmux_b;
endmodule

// File: tb/tb_gate_and_dmux_unit.sv
// Self-checking bench for gate_and_dmux_unit: directed corners plus random traffic
// against a behavioural model of the last-loaded results.
module tb_gate_and_dmux_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] a16, b16;
    logic        a, b, in, sel;
    logic        valid_out;
    logic [15:0] y16;
    logic        y, dmux_a, dmux_b;
`ifdef AND16_ZERO_FLAG_EN
    logic        y16_zero;
`endif

    int checks = 0;
    int errors = 0;

    // Model: what the outputs should show after the most recent edge.
    logic        m_valid;
    logic [15:0] m_y16;
    logic        m_y, m_da, m_db, m_zero;

    gate_and_dmux_unit #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .a16(a16), .b16(b16), .a(a), .b(b), .in(in), .sel(sel),
        .valid_out(valid_out), .y16(y16), .y(y), .dmux_a(dmux_a),
`ifdef AND16_ZERO_FLAG_EN
        .y16_zero(y16_zero),
`endif
        .dmux_b(dmux_b)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then update the model from the inputs that were sampled.
    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_y16 = 16'h0000; m_y = 0; m_da = 0; m_db = 0; m_zero = 0;
        end else begin
            m_valid = valid_in;
            if (valid_in) begin
                m_y16  = a16 & b16;
                m_y    = a && b;
                m_da   = in && (sel == 1'b0);
                m_db   = in && (sel == 1'b1);
                m_zero = ((a16 & b16) == 16'h0000);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; valid_in = 1; a16 = 16'hFFFF; b16 = 16'hFFFF; a = 1; b = 1; in = 1; sel = 1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (valid_out !== 1'b0 || y16 !== 16'h0000 || y !== 1'b0 || dmux_a !== 1'b0 || dmux_b !== 1'b0) begin
                errors++;
                $display("FAIL reset cyc%0d: got v=%b y16=%h y=%b da=%b db=%b, need all zero",
                         i, valid_out, y16, y, dmux_a, dmux_b);
            end
`ifdef AND16_ZERO_FLAG_EN
            checks++;
            if (y16_zero !== 1'b0) begin
                errors++;
                $display("FAIL reset_zero: got %b need 0", y16_zero);
            end
`endif
        end
        rst = 0;
    endtask

    task automatic test_wide_corners();
        logic [15:0] pats [18] = '{16'h0000, 16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF, 16'h00FF,
                                   16'hFF00, 16'h0F0F, 16'hF0F0, 16'h3333, 16'hCCCC, 16'hAAAA,
                                   16'h5555, 16'h1234, 16'hFEDC, 16'h00F0, 16'h0F00, 16'h1357};
        logic [15:0] exp;
        valid_in = 1;
        for (int i = 0; i < 18; i++) begin
            for (int j = 0; j < 18; j++) begin
                a16 = pats[i]; b16 = pats[j];
                exp = pats[i] & pats[j];
                cyc();
                checks++;
                if (valid_out !== 1'b1 || y16 !== exp) begin
                    errors++;
                    $display("FAIL and16_corner %h&%h: got v=%b y16=%h need v=1 y16=%h",
                             pats[i], pats[j], valid_out, y16, exp);
                end
            end
        end
        a16 = 16'h1234; b16 = 16'hFEDC;
        cyc();
        checks++;
        if (y16 !== 16'h1214) begin
            errors++;
            $display("FAIL and16_example: got %h need 1214", y16);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1000; k++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            a16 = 16'($urandom); b16 = 16'($urandom);
            a = 1'($urandom); b = 1'($urandom); in = 1'($urandom); sel = 1'($urandom);
            cyc();
            checks++;
            if (valid_out !== m_valid || y16 !== m_y16 || y !== m_y || dmux_a !== m_da || dmux_b !== m_db) begin
                errors++;
                $display("FAIL random#%0d: got v=%b y16=%h y=%b da=%b db=%b need v=%b y16=%h y=%b da=%b db=%b",
                         k, valid_out, y16, y, dmux_a, dmux_b, m_valid, m_y16, m_y, m_da, m_db);
            end
`ifdef AND16_ZERO_FLAG_EN
            checks++;
            if (y16_zero !== m_zero) begin
                errors++;
                $display("FAIL random_zero#%0d: got %b need %b", k, y16_zero, m_zero);
            end
`endif
        end
    endtask

    task automatic test_narrow();
        logic [3:0] exp_y = 4'b1000;
        valid_in = 1;
        for (int i = 0; i < 4; i++) begin
            a = i[1]; b = i[0];
            cyc();
            checks++;
            if (y !== exp_y[i] || valid_out !== 1'b1) begin
                errors++;
                $display("FAIL and2 ab=%0d%0d: got y=%b v=%b need y=%b v=1", i[1], i[0], y, valid_out, exp_y[i]);
            end
        end
    endtask

    task automatic test_demux();
        logic [3:0] exp_a = 4'b0010;
        logic [3:0] exp_b = 4'b1000;
        valid_in = 1;
        for (int i = 0; i < 4; i++) begin
            sel = i[1]; in = i[0];
            cyc();
            checks++;
            if (dmux_a !== exp_a[i] || dmux_b !== exp_b[i]) begin
                errors++;
                $display("FAIL dmux sel,in=%0d%0d: got (%b,%b) need (%b,%b)",
                         i[1], i[0], dmux_a, dmux_b, exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_hold();
        valid_in = 1; a16 = 16'hFFFF; b16 = 16'h00FF;
        cyc();
        valid_in = 0; a16 = 16'h0000; b16 = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (y16 !== 16'h00FF || valid_out !== 1'b0) begin
                errors++;
                $display("FAIL hold cyc%0d: got y16=%h v=%b need y16=00ff v=0", i, y16, valid_out);
            end
        end
        rst = 1;
        cyc();
        checks++;
        if (y16 !== 16'h0000) begin
            errors++;
            $display("FAIL hold_reset: got y16=%h need 0000", y16);
        end
        rst = 0;
    endtask

    task automatic test_reset_midstream();
        valid_in = 1; a16 = 16'hABCD; b16 = 16'hFFFF;
        cyc();
        rst = 1;
        cyc();
        rst = 0; valid_in = 0;
        cyc();
        checks++;
        if (valid_out !== 1'b0 || y16 !== 16'h0000) begin
            errors++;
            $display("FAIL midstream_flush: got v=%b y16=%h need v=0 y16=0000", valid_out, y16);
        end
        valid_in = 1; a16 = 16'h0F0F; b16 = 16'h00FF;
        cyc();
        checks++;
        if (valid_out !== 1'b1 || y16 !== 16'h000F) begin
            errors++;
            $display("FAIL midstream_first: got v=%b y16=%h need v=1 y16=000f", valid_out, y16);
        end
    endtask

`ifdef AND16_ZERO_FLAG_EN
    task automatic test_zero_flag();
        valid_in = 1; a16 = 16'hF0F0; b16 = 16'h0F0F;
        cyc();
        checks++;
        if (y16_zero !== 1'b1) begin
            errors++;
            $display("FAIL zero_flag_set: got %b need 1", y16_zero);
        end
        a16 = 16'h0001; b16 = 16'h0001;
        cyc();
        checks++;
        if (y16_zero !== 1'b0) begin
            errors++;
            $display("FAIL zero_flag_clr: got %b need 0", y16_zero);
        end
    endtask
`endif

    initial begin
        rst = 1; valid_in = 0; a16 = 0; b16 = 0; a = 0; b = 0; in = 0; sel = 0;
        m_valid = 0; m_y16 = 0; m_y = 0; m_da = 0; m_db = 0; m_zero = 0;
        @(negedge clk);
        test_reset();
        test_wide_corners();
        test_narrow();
        test_demux();
        test_hold();
        test_reset_midstream();
`ifdef AND16_ZERO_FLAG_EN
        test_zero_flag();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
